mem_responder: RTL and testbench
================================

# mem_responder

Target-side end of the CPU memory bus: decodes the byte address, active-low read strobe and two byte-lane write strobes driven by the bus controller, and services them from an internal word RAM plus a small memory-mapped I/O window. Writes commit once per strobe assertion on the addressed byte lanes. Reads return the full 16-bit word one clock later. Protocol violations are detected, counted and exposed through a status register. The block sits between the bus controller outputs and the CPU data-in path.

## Interface
- RAM_AW, 10: RAM word-address width. RAM holds 2^RAM_AW 16-bit words.
- IO_BASE, 16'hFF00: byte address of the I/O window. Must be 8-byte aligned. The window is 8 bytes (4 words).
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ADDR_BUF  in  16  byte address. Bit 0 selects the lane; [15:1] is the word address.
- DOUT_BUF  in  16  write data. A low-byte write uses [7:0]; a high-byte write uses [15:8] (controller pre-shifts).
- RDN_BUF  in  1  read strobe, active low.
- WRN0_BUF  in  1  low-lane write strobe, active low.
- WRN1_BUF  in  1  high-lane write strobe, active low.
- DIN  out  16  registered read data to CPU.
- PORT_OUT  out  16  general-purpose output register.
- PORT_IN  in  16  asynchronous general-purpose inputs.
- BUS_ERR  out  1  sticky protocol-error flag (mirror of STATUS[0]).

## Operation
- Decode: IO hit when ADDR_BUF[15:3] == IO_BASE[15:3]. Otherwise the access is a RAM access at word index ADDR_BUF[RAM_AW:1]. Upper bits are ignored, so addresses alias/wrap modulo RAM size.
- Write detect: registered copies WR0_Q and WR1_Q of the strobes. A lane write fires when the strobe is low now and its registered copy was high (falling edge). Exactly one commit per assertion, regardless of how long the strobe is held low.
- Both lanes falling in the same cycle is a word write. Lanes falling in different cycles produce two independent lane writes to the address present at each edge.
- Lane write: WRN0 edge writes DOUT_BUF[7:0] into word bits [7:0]. WRN1 edge writes DOUT_BUF[15:8] into bits [15:8]. The other byte is unchanged.
- Read: every cycle RDN_BUF is low and there is no error, DIN <= word at the address. Reads are side-effect free. When RDN_BUF is high, DIN holds its last value.
- Protocol error: RDN_BUF low while either WRN is low in the same cycle.
  - No write commits that cycle and DIN holds.
  - ERR is set.
  - ERR_CNT increments, saturating at 255.
  - The edge registers still update, so the write is lost rather than deferred.
- I/O registers, at word offsets from IO_BASE:
  - 0, PORT_OUT: read/write, byte-lane writable.
  - 1, PORT_IN: read-only. Two-flop synchronised copy of PORT_IN.
  - 2, CYCLES: read-only. Free-running 16-bit counter; increments every cycle and wraps FFFF->0000.
  - 3, STATUS: [0]=ERR, [7:1]=0, [15:8]=ERR_CNT. A low-lane write with DOUT_BUF[0]=1 clears both ERR and ERR_CNT; other writes are ignored. If an error occurs in the same cycle as a clear, the clear wins.
- Writes to read-only registers are ignored.

## Timing
- Reset (RESET high at an edge):
  - DIN=0, PORT_OUT=0, BUS_ERR=0, ERR_CNT=0, CYCLES=0, synchroniser flops=0.
  - WR0_Q=WR1_Q=0 (treated as "already low"), so a strobe held low through reset release does not write. It must be seen high for one cycle first.
  - RAM contents are not reset.
- Write latency: the commit happens at the edge where the falling level is first sampled. A read at the next edge returns the new data.
- Read latency: 1 clock. RDN_BUF low sampled at edge k gives DIN valid after edge k.
- PORT_IN latency: 2 clocks into the synchroniser, plus 1 read clock to DIN.
- CYCLES read value is the counter value at the sampling edge, before that edge's increment.
- Reset asserted mid-write: no commit on the reset edge. The strobe must return high before the next write.

## Test plan
- Word write/read: write 16'h1234 at 0x0010 with both strobes falling together, then read at 0x0010 -> DIN=16'h1234 one clock after RDN low.
- Byte lanes: word 0x0020=16'hAAAA, then WRN1 alone with DOUT_BUF=16'h5500 at 0x0021 -> read 0x0020 gives 16'h55AA. Then WRN0 alone with 16'h0077 -> read gives 16'h5577.
- Single commit: hold WRN0 low for 5 cycles while DOUT_BUF changes 01->02->03 at 0x0030 -> low byte = 01.
- Protocol error: RDN and WRN0 low together at 0x0040 (holding 16'hBEEF) with data 16'h0000 -> RAM unchanged, BUS_ERR=1, STATUS reads 16'h0101. After 300 such errors, STATUS[15:8]=FF. Writing 16'h0001 to IO_BASE+6 -> STATUS=0.
- I/O window: write 16'hC3C3 to IO_BASE -> PORT_OUT=C3C3. PORT_IN=16'h0F0F held 3 cycles, then read IO_BASE+2 -> 0F0F. Two CYCLES reads 10 clocks apart differ by 10, including across the FFFF wrap.
- Reset/alias: WRN0 held low through reset release -> no write. With RAM_AW=10, a write at 0x0802 is read back at 0x0002.

Source files
------------

// File: rtl/mem_responder.sv
// Purpose : target side of the CPU memory bus; word RAM plus a 4-word memory-mapped I/O window.
// Latency : writes commit on the edge that first sees a strobe low; read data appears on DIN one clock after RDN low.
// Backpressure: none; the bus controller owns timing, and read/write overlap is flagged as a protocol error.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   addr_buf_i   byte address; bit 0 = lane, [15:1] = word address
//   dout_buf_i   write data (controller pre-shifts high-byte data into [15:8])
//   rdn_buf_i    read strobe, active low
//   wrn0_buf_i   low-lane write strobe, active low
//   wrn1_buf_i   high-lane write strobe, active low
//   din_o        registered read data to the CPU
//   port_out_o   general-purpose output register (I/O word 0)
//   port_in_i    asynchronous general-purpose inputs (I/O word 1)
//   bus_err_o    sticky protocol-error flag (STATUS[0])
//
// I/O window at IO_BASE (must be 8-byte aligned), word offsets:
//   0 PORT_OUT (rw, byte-lane writable), 1 PORT_IN (ro, synchronised),
//   2 CYCLES (ro, free-running), 3 STATUS (ERR in [0], ERR_CNT in [15:8]; low-lane write of bit0=1 clears).

module mem_responder #(
    parameter int          RAM_AW  = 10,
    parameter logic [15:0] IO_BASE = 16'hFF00
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] addr_buf_i,
    input  logic [15:0] dout_buf_i,
    input  logic        rdn_buf_i,
    input  logic        wrn0_buf_i,
    input  logic        wrn1_buf_i,
    output logic [15:0] din_o,
    output logic [15:0] port_out_o,
    input  logic [15:0] port_in_i,
    output logic        bus_err_o
);

    localparam int RAM_WORDS = 1 << RAM_AW;

    localparam logic [1:0] OFF_PORT_OUT = 2'd0;
    localparam logic [1:0] OFF_PORT_IN  = 2'd1;
    localparam logic [1:0] OFF_CYCLES   = 2'd2;
    localparam logic [1:0] OFF_STATUS   = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0] mem [RAM_WORDS];

    logic        wr0_q;         // previous level of wrn0_buf_i
    logic        wr1_q;         // previous level of wrn1_buf_i
    logic [15:0] din_q,      din_d;
    logic [15:0] port_out_q, port_out_d;
    logic [15:0] sync1_q;       // first synchroniser stage for port_in_i
    logic [15:0] sync2_q;       // second (stable) synchroniser stage
    logic [15:0] cycles_q,   cycles_d;
    logic        err_q,      err_d;
    logic [7:0]  err_cnt_q,  err_cnt_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic              rd_act;
    logic              wr_lvl;
    logic              prot_err;
    logic              fall0;
    logic              fall1;
    logic              we0;
    logic              we1;
    logic              io_hit;
    logic [1:0]        io_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we0;
    logic              ram_we1;
    logic              status_clr;
    logic [15:0]       status_word;
    logic [15:0]       rd_data;

    always_comb begin
        rd_act   = ~rdn_buf_i;
        wr_lvl   = ~wrn0_buf_i | ~wrn1_buf_i;
        // Overlapping read and write strobes: the cycle is discarded.
        prot_err = rd_act & wr_lvl;

        // The edge registers reset to 0 ("already low"), so a strobe held
        // low across reset release must go high once before it can write.
        fall0 = ~wrn0_buf_i & wr0_q;
        fall1 = ~wrn1_buf_i & wr1_q;
        we0   = fall0 & ~prot_err;
        we1   = fall1 & ~prot_err;

        io_hit  = (addr_buf_i[15:3] == IO_BASE[15:3]);
        io_off  = addr_buf_i[2:1];
        // Upper address bits are dropped, so RAM aliases modulo its size.
        ram_idx = addr_buf_i[RAM_AW:1];

        // Reset edge never commits, even if a strobe falls on it.
        ram_we0 = we0 & ~io_hit & ~reset_i;
        ram_we1 = we1 & ~io_hit & ~reset_i;

        status_clr  = io_hit & (io_off == OFF_STATUS) & we0 & dout_buf_i[0];
        status_word = {err_cnt_q, 7'b0, err_q};
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = mem[ram_idx];
        if (io_hit) begin
            case (io_off)
                OFF_PORT_OUT: rd_data = port_out_q;
                OFF_PORT_IN:  rd_data = sync2_q;
                OFF_CYCLES:   rd_data = cycles_q;    // value before this edge's increment
                OFF_STATUS:   rd_data = status_word;
                default:      rd_data = 16'h0000;
            endcase
        end
    end

    always_comb begin
        din_d = din_q;
        if (rd_act && !prot_err) begin
            din_d = rd_data;
        end
    end

    // ------------------------------------------------------------------
    // I/O register next state
    // ------------------------------------------------------------------
    always_comb begin
        port_out_d = port_out_q;
        if (io_hit && io_off == OFF_PORT_OUT) begin
            if (we0) port_out_d[7:0]  = dout_buf_i[7:0];
            if (we1) port_out_d[15:8] = dout_buf_i[15:8];
        end
    end

    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        // A clear beats an error in the same cycle.
        if (status_clr) begin
            err_d     = 1'b0;
            err_cnt_d = 8'd0;
        end else if (prot_err) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        cycles_d = cycles_q + 16'd1;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr0_q      <= 1'b0;
            wr1_q      <= 1'b0;
            din_q      <= 16'h0000;
            port_out_q <= 16'h0000;
            sync1_q    <= 16'h0000;
            sync2_q    <= 16'h0000;
            cycles_q   <= 16'h0000;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            // Edge registers follow the strobes even in error cycles, so an
            // overlapped write is lost rather than deferred.
            wr0_q      <= wrn0_buf_i;
            wr1_q      <= wrn1_buf_i;
            din_q      <= din_d;
            port_out_q <= port_out_d;
            sync1_q    <= port_in_i;
            sync2_q    <= sync1_q;
            cycles_q   <= cycles_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // RAM contents survive reset; only the write enables are reset-gated.
    always_ff @(posedge clk_i) begin
        if (ram_we0) mem[ram_idx][7:0]  <= dout_buf_i[7:0];
        if (ram_we1) mem[ram_idx][15:8] <= dout_buf_i[15:8];
    end

    assign din_o      = din_q;
    assign port_out_o = port_out_q;
    assign bus_err_o  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Purpose : directed + randomized bench for mem_responder with a behavioural model.
// Latency : one bus step per clock; inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: none; the bench drives strobes directly.

module tb_mem_responder;

    localparam int          RAM_AW  = 10;
    localparam int          WORDS   = 1 << RAM_AW;
    localparam logic [15:0] IO_BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr_buf;
    logic [15:0] dout_buf;
    logic        rdn_buf;
    logic        wrn0_buf;
    logic        wrn1_buf;
    logic [15:0] din;
    logic [15:0] port_out;
    logic [15:0] port_in;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_responder #(.RAM_AW(RAM_AW), .IO_BASE(IO_BASE)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .addr_buf_i (addr_buf),
        .dout_buf_i (dout_buf),
        .rdn_buf_i  (rdn_buf),
        .wrn0_buf_i (wrn0_buf),
        .wrn1_buf_i (wrn1_buf),
        .din_o      (din),
        .port_out_o (port_out),
        .port_in_i  (port_in),
        .bus_err_o  (bus_err)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model
    logic [15:0] ram_m [WORDS];
    logic [15:0] port_out_m;
    bit          err_m;
    int          err_cnt_m;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rdn_buf  = 1'b1;
        wrn0_buf = 1'b1;
        wrn1_buf = 1'b1;
        repeat (n) step();
    endtask

    function automatic bit is_io(input logic [15:0] a);
        return (int'(a) / 8) == (int'(IO_BASE) / 8);
    endfunction

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % WORDS;
    endfunction

    function automatic logic [15:0] status_m();
        return 16'(err_cnt_m * 256 + (err_m ? 1 : 0));
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] lanes);
        int off;
        if (is_io(a)) begin
            off = (int'(a) % 8) / 2;
            if (off == 0) begin
                if (lanes[0]) port_out_m[7:0]  = d[7:0];
                if (lanes[1]) port_out_m[15:8] = d[15:8];
            end else if (off == 3 && lanes[0] && d[0]) begin
                err_m     = 1'b0;
                err_cnt_m = 0;
            end
        end else begin
            if (lanes[0]) ram_m[widx(a)][7:0]  = d[7:0];
            if (lanes[1]) ram_m[widx(a)][15:8] = d[15:8];
        end
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        int off;
        if (is_io(a)) begin
            off = (int'(a) % 8) / 2;
            if (off == 0) return port_out_m;
            return status_m();
        end
        return ram_m[widx(a)];
    endfunction

    function automatic void model_errors(input int n);
        err_m     = 1'b1;
        err_cnt_m = (err_cnt_m + n > 255) ? 255 : err_cnt_m + n;
    endfunction

    function automatic void model_reset();
        port_out_m = 16'h0000;
        err_m      = 1'b0;
        err_cnt_m  = 0;
    endfunction

    // One-cycle strobe assertion followed by a release cycle.
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] lanes);
        addr_buf = a;
        dout_buf = d;
        rdn_buf  = 1'b1;
        wrn0_buf = ~lanes[0];
        wrn1_buf = ~lanes[1];
        step();
        wrn0_buf = 1'b1;
        wrn1_buf = 1'b1;
        step();
        model_write(a, d, lanes);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        addr_buf = a;
        rdn_buf  = 1'b0;
        step();
        d       = din;
        rdn_buf = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [15:0] a);
        logic [15:0] v;
        bus_read(a, v);
        check(tag, v, model_read(a));
    endtask

    logic [15:0] v, v1, v2, c0, gap;
    logic [15:0] pool [16];
    logic [15:0] a, d;
    logic [1:0]  lanes;

    initial begin
        reset    = 1'b1;
        addr_buf = 16'h0000;
        dout_buf = 16'h0000;
        rdn_buf  = 1'b1;
        wrn0_buf = 1'b1;
        wrn1_buf = 1'b1;
        port_in  = 16'h0000;
        model_reset();
        for (int i = 0; i < WORDS; i++) ram_m[i] = 16'h0000;

        // ---- reset state ----
        step();
        step();
        check("rst_din", din, 16'h0000);
        check("rst_port_out", port_out, 16'h0000);
        check("rst_bus_err", {15'b0, bus_err}, 16'h0000);
        reset = 1'b0;
        idle(3);
        bus_read(IO_BASE + 16'd4, v);
        check("cycles_after_reset", v, 16'd3);
        read_check("rst_status", IO_BASE + 16'd6);
        read_check("rst_port_out_rd", IO_BASE);

        // ---- word write / read ----
        bus_write(16'h0010, 16'h1234, 2'b11);
        read_check("word_rw", 16'h0010);
        check("word_rw_value", din, 16'h1234);

        // ---- DIN holds while RDN is high ----
        idle(3);
        check("din_hold", din, 16'h1234);

        // ---- byte lanes ----
        bus_write(16'h0020, 16'hAAAA, 2'b11);
        bus_write(16'h0021, 16'h5500, 2'b10);
        bus_read(16'h0020, v);
        check("lane_hi", v, 16'h55AA);
        bus_write(16'h0020, 16'h0077, 2'b01);
        bus_read(16'h0020, v);
        check("lane_lo", v, 16'h5577);

        // ---- single commit per assertion ----
        bus_write(16'h0030, 16'hEE00, 2'b11);
        addr_buf = 16'h0030;
        wrn0_buf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dout_buf = 16'(i + 1);
            step();
        end
        wrn0_buf = 1'b1;
        step();
        model_write(16'h0030, 16'h0001, 2'b01);
        bus_read(16'h0030, v);
        check("single_commit", v, 16'hEE01);

        // ---- lanes falling in different cycles at different addresses ----
        bus_write(16'h0060, 16'h0000, 2'b11);
        bus_write(16'h0062, 16'h0000, 2'b11);
        addr_buf = 16'h0060;
        dout_buf = 16'h1111;
        wrn0_buf = 1'b0;
        step();
        addr_buf = 16'h0063;
        dout_buf = 16'h2222;
        wrn1_buf = 1'b0;
        step();
        wrn0_buf = 1'b1;
        wrn1_buf = 1'b1;
        step();
        model_write(16'h0060, 16'h1111, 2'b01);
        model_write(16'h0063, 16'h2222, 2'b10);
        bus_read(16'h0060, v);
        check("split_lane_a", v, 16'h0011);
        bus_read(16'h0062, v);
        check("split_lane_b", v, 16'h2200);

        // ---- protocol error ----
        bus_write(16'h0040, 16'hBEEF, 2'b11);
        bus_read(16'h0010, v);
        addr_buf = 16'h0040;
        dout_buf = 16'h0000;
        rdn_buf  = 1'b0;
        wrn0_buf = 1'b0;
        step();
        model_errors(1);
        check("err_din_hold", din, 16'h1234);
        check("err_flag", {15'b0, bus_err}, 16'h0001);
        idle(1);
        bus_read(16'h0040, v);
        check("err_ram_unchanged", v, 16'hBEEF);
        bus_read(IO_BASE + 16'd6, v);
        check("err_status_0101", v, 16'h0101);
        // Writes that must not clear STATUS.
        bus_write(IO_BASE + 16'd6, 16'h0100, 2'b11);
        bus_write(IO_BASE + 16'd7, 16'h0100, 2'b10);
        read_check("status_no_clear", IO_BASE + 16'd6);
        // 299 more error cycles (level-detected) saturate the counter.
        addr_buf = 16'h0040;
        rdn_buf  = 1'b0;
        wrn0_buf = 1'b0;
        repeat (299) step();
        model_errors(299);
        idle(1);
        bus_read(IO_BASE + 16'd6, v);
        check("err_cnt_sat", v, 16'hFF01);
        bus_write(IO_BASE + 16'd6, 16'h0001, 2'b01);
        bus_read(IO_BASE + 16'd6, v);
        check("status_clear", v, 16'h0000);
        check("bus_err_cleared", {15'b0, bus_err}, 16'h0000);

        // ---- I/O window ----
        bus_write(IO_BASE, 16'hC3C3, 2'b11);
        check("port_out_pin", port_out, 16'hC3C3);
        read_check("port_out_rd", IO_BASE);
        // Writes to read-only registers are ignored.
        bus_write(IO_BASE + 16'd2, 16'hFFFF, 2'b11);
        bus_write(IO_BASE + 16'd4, 16'hFFFF, 2'b11);
        check("ro_write_ignored", port_out, 16'hC3C3);
        port_in = 16'h0F0F;
        idle(3);
        bus_read(IO_BASE + 16'd2, v);
        check("port_in_sync", v, 16'h0F0F);
        // A change one clock before the read is not yet visible.
        port_in = 16'hA5A5;
        bus_read(IO_BASE + 16'd2, v);
        check("port_in_latency", v, 16'h0F0F);
        idle(2);
        bus_read(IO_BASE + 16'd2, v);
        check("port_in_new", v, 16'hA5A5);

        // ---- CYCLES deltas, then across the wrap ----
        bus_read(IO_BASE + 16'd4, v1);
        idle(9);
        bus_read(IO_BASE + 16'd4, v2);
        check("cycles_delta", v2 - v1, 16'd10);
        c0  = v2;
        gap = 16'hFFFA - c0 - 16'd1;
        idle(int'(gap));
        bus_read(IO_BASE + 16'd4, v1);
        check("cycles_abs", v1, 16'hFFFA);
        idle(9);
        bus_read(IO_BASE + 16'd4, v2);
        check("cycles_wrap_val", v2, 16'h0004);
        check("cycles_wrap_delta", v2 - v1, 16'd10);

        // ---- aliasing ----
        bus_write(16'h0802, 16'h5A5A, 2'b11);
        bus_read(16'h0002, v);
        check("alias", v, 16'h5A5A);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 16; i++) begin
            pool[i] = 16'($urandom_range(0, WORDS - 1) * 2);
            bus_write(pool[i], 16'($urandom), 2'b11);
        end
        for (int i = 0; i < 120; i++) begin
            a = pool[$urandom_range(0, 15)];
            a = a | 16'(($urandom_range(0, 31) << 11) | $urandom_range(0, 1));
            if (is_io(a)) a[15] = 1'b0;
            d = 16'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    lanes = 2'($urandom_range(1, 3));
                    bus_write(a, d, lanes);
                end
                1: read_check("rand_ram_rd", a);
                2: begin
                    lanes = 2'($urandom_range(1, 3));
                    bus_write(IO_BASE, d, lanes);
                    check("rand_port_out", port_out, port_out_m);
                end
                default: begin
                    read_check("rand_port_rd", IO_BASE);
                end
            endcase
        end

        // ---- reset mid-write and strobe held low through release ----
        bus_write(16'h0050, 16'h1111, 2'b11);
        addr_buf = 16'h0050;
        dout_buf = 16'h2222;
        wrn0_buf = 1'b0;
        wrn1_buf = 1'b0;
        reset    = 1'b1;
        step();
        model_reset();
        check("rst2_din", din, 16'h0000);
        check("rst2_port_out", port_out, 16'h0000);
        reset = 1'b0;
        step();
        step();
        wrn0_buf = 1'b1;
        wrn1_buf = 1'b1;
        step();
        bus_read(16'h0050, v);
        check("rst_no_write", v, 16'h1111);
        read_check("rst2_status", IO_BASE + 16'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
